mul8_seq_ctrl: RTL and testbench
================================

Name: mul8_seq_ctrl

Overview:
- Sequencer that produces 8x8 unsigned products by time-sharing one external 4x4 array multiplier: four nibble passes, shift-accumulated.
- Arbitrates between two requesters (round-robin) and returns the product with a requester tag over a valid/ready output.
- Sits between the 4x4 multiplier core and the front-end operand sources.

Parameters:
- CNT_W, 16, width of the completed-operation counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; combinational.
- req_a  in  16  operand A; {req1_a[15:8], req0_a[7:0]}.
- req_b  in  16  operand B; same packing.
- mul_a  out  4  nibble to multiplier input m.
- mul_b  out  4  nibble to multiplier input q.
- mul_p  in  8  combinational product from multiplier, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_prod  out  16  8x8 unsigned product.
- out_tag  out  1  requester index that owns out_prod.
- busy  out  1  high in any state other than IDLE.
- op_count  out  CNT_W  completed-operation count.

Behaviour:
- Reset (async assert, any state, mid-operation included):
  - state=IDLE, pass=0, accumulator=0, out_valid=0, out_prod=0, out_tag=0, op_count=0, busy=0.
  - Round-robin pointer set so requester 0 has priority first.
  - Any in-flight operation is discarded; no partial result is emitted.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = requester with priority if its req_valid is high, else the other one if valid.
  - req_ready = one-hot grant only in IDLE; 0 in all other states.
  - Accept edge (req_valid[g]&req_ready[g]): latch A, B, tag=g; clear accumulator; pass=0; go to CALC; priority moves to the other requester.
  - A lone requester is served back-to-back.
- CALC, one pass per cycle, pass 0..3. Nibble selection (mul_a, mul_b, shift):
  - pass0: A[3:0], B[3:0], shift 0
  - pass1: A[7:4], B[3:0], shift 4
  - pass2: A[3:0], B[7:4], shift 4
  - pass3: A[7:4], B[7:4], shift 8
- Each CALC edge: acc <= acc + (mul_p << shift), 16-bit. No overflow is possible: the maximum 0xFF*0xFF = 0xFE01.
- On the pass3 edge: out_prod <= final sum, out_valid <= 1, state <= DONE.
- mul_a/mul_b = 0 in IDLE and DONE.
- Latency: out_valid rises 4 cycles after the accept edge. Minimum issue interval: 5 cycles plus one IDLE cycle.
- DONE:
  - out_prod and out_tag are held stable while out_valid=1 and out_ready=0 (unbounded backpressure).
  - Edge with out_ready=1: out_valid <= 0, op_count <= op_count+1 (wrap), state <= IDLE.
  - out_ready while not in DONE is ignored.
- Requests never preempt an operation. A requester's req_valid may drop before grant with no effect.
- busy = (state != IDLE).

Test Plan:
- Single op: req0 A=0x12, B=0x34, out_ready=1 -> out_valid 4 cycles after accept; out_prod=0x03A8, out_tag=0, op_count=1.
- Max operands: req1 A=0xFF, B=0xFF -> out_prod=0xFE01, out_tag=1. Per-pass mul_a/mul_b sequence F/F, F/F, F/F, F/F. Zero operands A=0x00, B=0xC3 -> out_prod=0x0000.
- Arbitration:
  - Both req_valid held high, four ops -> grant order 0,1,0,1 after reset; out_tag sequence 0,1,0,1.
  - Only req1 valid -> served consecutively.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_prod, out_tag and out_valid stable; req_ready=00; op_count unchanged until the out_ready=1 edge.
- Reset mid-op: assert rst during pass 2 -> outputs return to reset values immediately (async); no out_valid after release; next op 0x0A*0x0B=0x006E is correct.
- Counter wrap with CNT_W=2: 5 completed ops -> op_count 1,2,3,0,1.

Source files
------------

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiply sequencer over a shared 4x4 multiplier
// Two requesters arbitrated round-robin; four nibble passes shift-accumulated into a 16-bit product.
module mul8_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_prod,
  output logic             out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       pass_q, pass_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             tag_q, tag_d;
  logic             prio_q, prio_d;
  logic [15:0]      prod_q, prod_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             gnt_vld;
  logic             gnt_idx;
  logic [15:0]      pp;
  logic [15:0]      sum;

  // The priority holder wins when valid; otherwise fall through to the other requester.
  assign gnt_vld = |req_valid;
  assign gnt_idx = req_valid[prio_q] ? prio_q : ~prio_q;

  assign req_ready = (state_q == IDLE && gnt_vld) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // pass[0] selects the high nibble of A, pass[1] the high nibble of B.
  assign mul_a = (state_q == CALC) ? (pass_q[0] ? a_q[7:4] : a_q[3:0]) : 4'h0;
  assign mul_b = (state_q == CALC) ? (pass_q[1] ? b_q[7:4] : b_q[3:0]) : 4'h0;

  always_comb begin
    pp = {8'h00, mul_p};
    case (pass_q)
      2'd1, 2'd2: pp = {4'h0, mul_p, 4'h0};
      2'd3:       pp = {mul_p, 8'h00};
      default:    pp = {8'h00, mul_p};
    endcase
  end

  assign sum = acc_q + pp;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    prio_d  = prio_q;
    prod_d  = prod_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d     = gnt_idx ? req_a[15:8] : req_a[7:0];
          b_d     = gnt_idx ? req_b[15:8] : req_b[7:0];
          tag_d   = gnt_idx;
          prio_d  = ~gnt_idx;
          acc_d   = 16'h0000;
          pass_d  = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = sum;
        pass_d = pass_q + 2'd1;
        if (pass_q == 2'd3) begin
          prod_d  = sum;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= 2'd0;
      acc_q   <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      tag_q   <= 1'b0;
      prio_q  <= 1'b0;
      prod_q  <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      prio_q  <= prio_d;
      prod_q  <= prod_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_prod  = prod_q;
  assign out_tag   = tag_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - directed self-checking bench for mul8_seq_ctrl
// Uses CNT_W=2 so the counter wrap is visible; the 4x4 multiplier is modelled in the bench.
module tb_mul8_seq_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [15:0]      req_a = 16'h0000;
  logic [15:0]      req_b = 16'h0000;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_p;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_prod;
  logic             out_tag;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

  mul8_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag),
    .busy(busy), .op_count(op_count)
  );

  task automatic apply_reset();
    req_valid = 2'b00;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  // Issues one request, waits for completion with out_ready=1; reports grant, latency, result, nibble trace.
  task automatic run_op(input logic [1:0] vld, input logic hold, input logic [15:0] a, input logic [15:0] b,
                        output logic ok, output logic [1:0] gnt, output int lat,
                        output logic [15:0] prod, output logic tag, output logic [31:0] trace);
    int n;
    req_valid = vld; req_a = a; req_b = b; out_ready = 1'b1;
    #1;
    n = 0; lat = 0; trace = 32'h0; prod = 16'h0; tag = 1'b0;
    while (req_ready == 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    gnt = req_ready;
    @(posedge clk); #1;
    if (!hold) req_valid = 2'b00;
    while (!out_valid && lat < 20) begin
      if (lat < 4) trace[lat*8 +: 8] = {mul_a, mul_b};
      @(posedge clk); #1; lat++;
    end
    prod = out_prod;
    tag  = out_tag;
    ok   = (n < 20) && (lat < 20);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_prod !== 16'h0) begin errors++; $display("FAIL reset_prod got %h want 0000", out_prod); end
    checks++; if (busy !== 1'b0 || out_tag !== 1'b0) begin errors++; $display("FAIL reset_busy_tag got %b%b want 00", busy, out_tag); end
    checks++; if (op_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", op_count); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_idle got %b want 00", req_ready); end
    req_valid = 2'b11; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_priority got %b want 01", req_ready); end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_single();
    logic ok; logic [1:0] g; int lat; logic [15:0] p; logic t; logic [31:0] tr;
    run_op(2'b01, 1'b0, 16'h0012, 16'h0034, ok, g, lat, p, t, tr);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %b want 1", ok); end
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", g); end
    checks++; if (lat != 4) begin errors++; $display("FAIL single_latency got %0d want 4", lat); end
    checks++; if (p !== 16'h03A8) begin errors++; $display("FAIL single_prod got %h want 03a8", p); end
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL single_tag got %b want 0", t); end
    checks++; if (tr !== 32'h1323_1424) begin errors++; $display("FAIL single_nibbles got %h want 13231424", tr); end
    checks++; if (op_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", op_count); end
    checks++; if (busy !== 1'b0 || mul_a !== 4'h0 || mul_b !== 4'h0) begin
      errors++; $display("FAIL single_idle_after got busy=%b mul=%h%h want 0 00", busy, mul_a, mul_b); end
  endtask

  task automatic test_operands();
    logic ok; logic [1:0] g; int lat; logic [15:0] p; logic t; logic [31:0] tr;
    run_op(2'b10, 1'b0, 16'hFF00, 16'hFF00, ok, g, lat, p, t, tr);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL max_timeout got %b want 1", ok); end
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL max_prod got %h want fe01", p); end
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL max_tag got %b want 1", t); end
    checks++; if (tr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL max_nibbles got %h want ffffffff", tr); end
    run_op(2'b01, 1'b0, 16'h0000, 16'h00C3, ok, g, lat, p, t, tr);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_timeout got %b want 1", ok); end
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL zero_prod got %h want 0000", p); end
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL zero_tag got %b want 0", t); end
    checks++; if (op_count !== 2'd3) begin errors++; $display("FAIL zero_count got %0d want 3", op_count); end
  endtask

  // Counts after reset: 1,2,3,0 with both valid, then 1,2 with req1 alone.
  task automatic test_arbitration();
    logic ok; logic [1:0] g; int lat; logic [15:0] p; logic t; logic [31:0] tr;
    logic [1:0] exp_cnt;
    logic       exp_tag;
    logic [15:0] exp_p;
    apply_reset();
    exp_cnt = 2'd0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        run_op(2'b11, 1'b1, 16'h0512, 16'h0734, ok, g, lat, p, t, tr);
        exp_tag = (i % 2 == 1);
      end else begin
        run_op(2'b10, 1'b0, 16'h0512, 16'h0734, ok, g, lat, p, t, tr);
        exp_tag = 1'b1;
      end
      exp_p = exp_tag ? 16'h0023 : 16'h03A8;
      exp_cnt = exp_cnt + 2'd1;
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL arb_timeout op %0d got %b want 1", i, ok); end
      checks++; if (t !== exp_tag) begin errors++; $display("FAIL arb_tag op %0d got %b want %b", i, t, exp_tag); end
      checks++; if (p !== exp_p) begin errors++; $display("FAIL arb_prod op %0d got %h want %h", i, p, exp_p); end
      checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL arb_count op %0d got %0d want %0d", i, op_count, exp_cnt); end
    end
    req_valid = 2'b00; #1;
  endtask

  task automatic test_backpressure();
    int n;
    logic [CNT_W-1:0] cnt0;
    cnt0 = op_count;
    req_valid = 2'b10; req_a = 16'h3300; req_b = 16'h2100; out_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_prod !== 16'h0693 || out_tag !== 1'b1) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b p=%h t=%b want 1 0693 1", i, out_valid, out_prod, out_tag); end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1 || op_count !== cnt0) begin
        errors++; $display("FAIL bp_stall cyc %0d got rdy=%b busy=%b cnt=%0d want 00 1 %0d", i, req_ready, busy, op_count, cnt0); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || op_count !== cnt0 + 2'd1) begin
      errors++; $display("FAIL bp_release got v=%b cnt=%0d want 0 %0d", out_valid, op_count, cnt0 + 2'd1); end
  endtask

  task automatic test_reset_midop();
    logic ok; logic [1:0] g; int lat; logic [15:0] p; logic t; logic [31:0] tr;
    logic seen;
    req_valid = 2'b01; req_a = 16'h0055; req_b = 16'h0055; out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || mul_a !== 4'h5) begin errors++; $display("FAIL midop_pass2 got busy=%b mul_a=%h want 1 5", busy, mul_a); end
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_prod !== 16'h0 || op_count !== 2'd0) begin
      errors++; $display("FAIL midop_async got busy=%b v=%b p=%h cnt=%0d want 0 0 0000 0", busy, out_valid, out_prod, op_count); end
    checks++; if (mul_a !== 4'h0 || mul_b !== 4'h0) begin errors++; $display("FAIL midop_mul got %h%h want 00", mul_a, mul_b); end
    #2; rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_result got %b want 0", seen); end
    run_op(2'b01, 1'b0, 16'h000A, 16'h000B, ok, g, lat, p, t, tr);
    checks++; if (ok !== 1'b1 || p !== 16'h006E || t !== 1'b0) begin
      errors++; $display("FAIL midop_next got ok=%b p=%h t=%b want 1 006e 0", ok, p, t); end
    checks++; if (op_count !== 2'd1) begin errors++; $display("FAIL midop_count got %0d want 1", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_operands();
    test_arbitration();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
